// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port 32x32 data memory between core (priority) and dbg, with a dbg anti-starvation counter.
// Latency: grant combinational in cycle N, memory command registered in N+1, read data valid in N+2.
// Backpressure: an ungranted requester holds its request; nothing is queued and at most one grant issues per cycle.
`timescale 1ns/1ps
module dmem_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int STALL_W  = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_c_req,
   input  logic               i_c_we,
   input  logic [31:0]        i_c_addr,
   input  logic [31:0]        i_c_wdata,
   output logic               o_c_gnt,
   output logic               o_c_rvalid,
   output logic [31:0]        o_c_rdata,
   input  logic               i_d_req,
   input  logic               i_d_we,
   input  logic [31:0]        i_d_addr,
   input  logic [31:0]        i_d_wdata,
   output logic               o_d_gnt,
   output logic               o_d_rvalid,
   output logic [31:0]        o_d_rdata,
   output logic               o_mem_we,
   output logic [31:0]        o_mem_addr,
   output logic [31:0]        o_mem_wdata,
   input  logic [31:0]        i_mem_rdata,
   output logic [STALL_W-1:0] o_stall_cnt
);

   // A zero MAX_WAIT still needs a 1-bit counter so the declaration stays legal.
   localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0]  r_wait_cnt;
   logic               r_mem_we;
   logic [31:0]        r_mem_addr;
   logic [31:0]        r_mem_wdata;
   logic               r_c_pend;
   logic               r_d_pend;
   logic               r_c_rvalid;
   logic               r_d_rvalid;
   logic [31:0]        r_c_rdata;
   logic [31:0]        r_d_rdata;
   logic [STALL_W-1:0] r_stall_cnt;

   logic               w_d_wins;
   logic               w_c_gnt;
   logic               w_d_gnt;

   // dbg overrides core priority once it has been denied MAX_WAIT cycles in a row.
   if (MAX_WAIT == 0) begin : g_dbg_strict
      assign w_d_wins = 1'b1;
   end else begin : g_dbg_wait
      assign w_d_wins = (r_wait_cnt >= WAIT_MAX);
   end

   // The two grant terms are mutually exclusive by construction; reset masks both.
   assign w_d_gnt = !i_rst && i_d_req && (!i_c_req || w_d_wins);
   assign w_c_gnt = !i_rst && i_c_req && !(i_d_req && w_d_wins);

   // Count consecutive denied dbg cycles, saturating at MAX_WAIT.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wait_cnt <= '0;
      end else if (!i_d_req || w_d_gnt) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_MAX) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // Register the granted command toward memory; address/data hold when idle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else if (w_c_gnt) begin
         r_mem_we    <= i_c_we;
         r_mem_addr  <= i_c_addr;
         r_mem_wdata <= i_c_wdata;
      end else if (w_d_gnt) begin
         r_mem_we    <= i_d_we;
         r_mem_addr  <= i_d_addr;
         r_mem_wdata <= i_d_wdata;
      end else begin
         r_mem_we    <= 1'b0;
      end
   end

   // Tag a granted read with its port so the data returns on the right channel.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_c_pend <= 1'b0;
         r_d_pend <= 1'b0;
      end else begin
         r_c_pend <= w_c_gnt && !i_c_we;
         r_d_pend <= w_d_gnt && !i_d_we;
      end
   end

   // Capture memory read data during the command cycle; rdata holds between responses.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_c_rvalid <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_c_rdata  <= '0;
         r_d_rdata  <= '0;
      end else begin
         r_c_rvalid <= r_c_pend;
         r_d_rvalid <= r_d_pend;
         if (r_c_pend) begin
            r_c_rdata <= i_mem_rdata;
         end
         if (r_d_pend) begin
            r_d_rdata <= i_mem_rdata;
         end
      end
   end

   // Saturating count of cycles where the core wanted the memory but did not get it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stall_cnt <= '0;
      end else if (i_c_req && !w_c_gnt && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign o_c_gnt     = w_c_gnt;
   assign o_d_gnt     = w_d_gnt;
   assign o_c_rvalid  = r_c_rvalid;
   assign o_c_rdata   = r_c_rdata;
   assign o_d_rvalid  = r_d_rvalid;
   assign o_d_rdata   = r_d_rdata;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then randomized traffic.
// A transaction-level model (grant rules, array memory, response queue) is compared every cycle.
// A second instance with MAX_WAIT=0 is checked for dbg strict priority.
`timescale 1ns/1ps
module tb_dmem_arbiter;
   localparam int MAXW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        c_req, c_we, d_req, d_we;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic        c_gnt, c_rvalid, d_gnt, d_rvalid, mem_we;
   logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [15:0] stall_cnt;
   logic        z_c_gnt, z_c_rvalid, z_d_gnt, z_d_rvalid, z_mem_we;
   logic [31:0] z_c_rdata, z_d_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;
   logic [15:0] z_stall;
   logic        mem_init;

   dmem_arbiter #(.MAX_WAIT(MAXW), .STALL_W(16)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
      .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
      .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
      .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata), .o_stall_cnt(stall_cnt));

   dmem_arbiter #(.MAX_WAIT(0), .STALL_W(16)) dut0 (
      .i_clk(clk), .i_rst(rst),
      .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
      .o_c_gnt(z_c_gnt), .o_c_rvalid(z_c_rvalid), .o_c_rdata(z_c_rdata),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
      .o_d_gnt(z_d_gnt), .o_d_rvalid(z_d_rvalid), .o_d_rdata(z_d_rdata),
      .o_mem_we(z_mem_we), .o_mem_addr(z_mem_addr), .o_mem_wdata(z_mem_wdata),
      .i_mem_rdata(z_mem_rdata), .o_stall_cnt(z_stall));

   function automatic logic [31:0] init_val(input int i);
      return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
   endfunction

   // Environment memory: combinational read, write at the clock edge.
   logic [31:0] tb_mem [32];
   assign mem_rdata   = tb_mem[mem_addr[4:0]];
   assign z_mem_rdata = tb_mem[z_mem_addr[4:0]];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) tb_mem[i] <= init_val(i);
      end else if (mem_we) begin
         tb_mem[mem_addr[4:0]] <= mem_wdata;
      end
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: transaction-level view of the arbiter.
   typedef struct { int due; bit port; logic [31:0] data; } rsp_t;
   rsp_t        rq[$];
   logic [31:0] mmem [32];
   logic        m_mem_we;
   logic [31:0] m_mem_addr, m_mem_wdata, m_c_rdata, m_d_rdata;
   int          m_stall, m_wait;
   logic        m_c_gnt, m_d_gnt, m_c_rv, m_d_rv;
   logic        g_we;
   logic [31:0] g_addr, g_wd;
   bit          g_port;

   always @(negedge clk) begin
      if (cyc == 0) begin
         for (int i = 0; i < 32; i++) mmem[i] = init_val(i);
         m_mem_we = 1'b0; m_mem_addr = '0; m_mem_wdata = '0;
         m_c_rdata = '0; m_d_rdata = '0; m_stall = 0; m_wait = 0;
         m_c_gnt = 1'b0; m_d_gnt = 1'b0;
      end
      // Responses scheduled for this cycle become visible now.
      m_c_rv = 1'b0;
      m_d_rv = 1'b0;
      while (rq.size() > 0 && rq[0].due <= cyc) begin
         if (rq[0].due == cyc) begin
            if (rq[0].port) begin m_d_rv = 1'b1; m_d_rdata = rq[0].data; end
            else begin m_c_rv = 1'b1; m_c_rdata = rq[0].data; end
         end
         void'(rq.pop_front());
      end
      // Grant rule: single requester wins; on contention core wins unless dbg is starved.
      m_c_gnt = 1'b0;
      m_d_gnt = 1'b0;
      if (!rst) begin
         if (c_req && d_req) begin
            if (m_wait >= MAXW) m_d_gnt = 1'b1; else m_c_gnt = 1'b1;
         end else if (c_req) begin
            m_c_gnt = 1'b1;
         end else if (d_req) begin
            m_d_gnt = 1'b1;
         end
      end
      chk("c_gnt", {31'd0, c_gnt}, {31'd0, m_c_gnt});
      chk("d_gnt", {31'd0, d_gnt}, {31'd0, m_d_gnt});
      chk("mem_we", {31'd0, mem_we}, {31'd0, m_mem_we});
      chk("mem_addr", mem_addr, m_mem_addr);
      chk("mem_wdata", mem_wdata, m_mem_wdata);
      chk("c_rvalid", {31'd0, c_rvalid}, {31'd0, m_c_rv});
      chk("c_rdata", c_rdata, m_c_rdata);
      chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, m_d_rv});
      chk("d_rdata", d_rdata, m_d_rdata);
      chk("stall_cnt", {16'd0, stall_cnt}, 32'(m_stall));
      // Advance to the next cycle's visible state.
      if (rst) begin
         m_mem_we = 1'b0; m_mem_addr = '0; m_mem_wdata = '0;
         m_c_rdata = '0; m_d_rdata = '0; m_stall = 0; m_wait = 0;
         rq.delete();
      end else begin
         if (m_c_gnt || m_d_gnt) begin
            g_port = m_d_gnt;
            g_we   = m_d_gnt ? d_we : c_we;
            g_addr = m_d_gnt ? d_addr : c_addr;
            g_wd   = m_d_gnt ? d_wdata : c_wdata;
            m_mem_we = g_we; m_mem_addr = g_addr; m_mem_wdata = g_wd;
            if (g_we) mmem[g_addr[4:0]] = g_wd;
            else rq.push_back('{cyc + 2, g_port, mmem[g_addr[4:0]]});
         end else begin
            m_mem_we = 1'b0;
         end
         if (c_req && !m_c_gnt && m_stall < 65535) m_stall++;
         if (!d_req || m_d_gnt) m_wait = 0;
         else if (m_wait < MAXW) m_wait++;
      end
      cyc++;
   end

   task automatic drive(input logic r, input logic cr, input logic cw, input logic [31:0] ca,
                        input logic [31:0] cd, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd);
      @(posedge clk); #1;
      rst = r; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
      d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
      #3;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] hi;
      hi = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFE0) : 32'd0;
      return hi | 32'($urandom_range(0, 31));
   endfunction

   initial begin
      int k;
      rst = 1'b1; mem_init = 1'b1;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'd7; c_wdata = '0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd9; d_wdata = '0;

      // Reset held two cycles with both requesting.
      @(posedge clk); #1; mem_init = 1'b0; #3;
      chk("rst_c_gnt", {31'd0, c_gnt}, 32'd0);
      chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 32'd7, 32'd0, 1'b1, 1'b0, 32'd9, 32'd0);
      chk("rst2_c_gnt", {31'd0, c_gnt}, 32'd0);
      chk("rst2_rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd0);
      drive(1'b0, 1'b1, 1'b0, 32'd7, 32'd0, 1'b1, 1'b0, 32'd9, 32'd0);
      chk("rel_c_gnt", {31'd0, c_gnt}, 32'd1);
      chk("rel_d_gnt", {31'd0, d_gnt}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd9, 32'd0);
      chk("rel2_d_gnt", {31'd0, d_gnt}, 32'd1);

      // Core write then read of the same address.
      drive(1'b0, 1'b1, 1'b1, 32'd3, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("cw_gnt", {31'd0, c_gnt}, 32'd1);
      drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("cw_mem_we", {31'd0, mem_we}, 32'd1);
      chk("cw_mem_addr", mem_addr, 32'd3);
      chk("cw_mem_wdata", mem_wdata, 32'hDEADBEEF);
      idle();
      chk("cr_mem_we", {31'd0, mem_we}, 32'd0);
      idle();
      chk("cr_rvalid", {31'd0, c_rvalid}, 32'd1);
      chk("cr_rdata", c_rdata, 32'hDEADBEEF);
      chk("cr_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      idle();
      chk("cr_rvalid_off", {31'd0, c_rvalid}, 32'd0);
      chk("cr_rdata_hold", c_rdata, 32'hDEADBEEF);

      // Starvation guard: both requesting for ten cycles.
      k = 0;
      for (int i = 0; i < 10; i++) begin
         logic ed;
         ed = (i == 4 || i == 9);
         drive(1'b0, 1'b1, 1'b1, 32'(8 + k), 32'(k), 1'b1, 1'b0, 32'd20, 32'd0);
         chk("starve_d_gnt", {31'd0, d_gnt}, {31'd0, ed});
         chk("starve_c_gnt", {31'd0, c_gnt}, {31'd0, !ed});
         if (!ed) k++;
      end
      idle();
      chk("starve_stall", {16'd0, stall_cnt}, 32'd2);
      chk("model_stall", 32'(m_stall), 32'd2);

      // dbg-only loader burst, then read back.
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0, 32'd1);
      chk("ld_gnt", {31'd0, d_gnt}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd1, 32'd2);
      chk("ld_we0", {31'd0, mem_we}, 32'd1);
      chk("ld_addr0", mem_addr, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd2, 32'd3);
      chk("ld_wd1", mem_wdata, 32'd2);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd1, 32'd0);
      chk("ld_we2", {31'd0, mem_we}, 32'd1);
      chk("ld_wd2", mem_wdata, 32'd3);
      idle();
      chk("ld_rd_we", {31'd0, mem_we}, 32'd0);
      idle();
      chk("ld_rvalid", {31'd0, d_rvalid}, 32'd1);
      chk("ld_rdata", d_rdata, 32'd2);
      chk("ld_c_rvalid", {31'd0, c_rvalid}, 32'd0);

      // Reset in the command cycle of a core read; MAX_WAIT=0 instance checked alongside.
      drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0);
      chk("mr_c_gnt", {31'd0, c_gnt}, 32'd1);
      drive(1'b1, 1'b1, 1'b0, 32'd3, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0);
      chk("mr_rst_gnt", {30'd0, c_gnt, d_gnt}, 32'd0);
      chk("mr_rst_z_gnt", {30'd0, z_c_gnt, z_d_gnt}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0);
         if (i < 2) chk("mr_no_rvalid", {31'd0, c_rvalid}, 32'd0);
         if (i == 0) chk("mr_stall0", {16'd0, stall_cnt}, 32'd0);
         chk("mr_c_gnt_seq", {31'd0, c_gnt}, {31'd0, i < 4});
         chk("mr_d_gnt_seq", {31'd0, d_gnt}, {31'd0, i == 4});
         chk("z_d_gnt", {31'd0, z_d_gnt}, 32'd1);
         chk("z_c_gnt", {31'd0, z_c_gnt}, 32'd0);
         chk("z_stall", {16'd0, z_stall}, 32'(i));
      end
      idle();

      // Randomized traffic; an ungranted request is held unchanged.
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 99) == 0);
         if (!(c_req && !m_c_gnt)) begin
            c_req = ($urandom_range(0, 99) < 60); c_we = 1'($urandom_range(0, 1));
            c_addr = rnd_addr(); c_wdata = $urandom;
         end
         if (!(d_req && !m_d_gnt)) begin
            d_req = ($urandom_range(0, 99) < 45); d_we = 1'($urandom_range(0, 1));
            d_addr = rnd_addr(); d_wdata = $urandom;
         end
      end
      for (int n = 0; n < 4; n++) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter in front of the single-port 32x32 data memory. It shares the memory between the pipeline MEM-stage port (core) and the debug/loader port (dbg). The core has priority; a saturating wait counter guarantees dbg forward progress. Memory commands are registered, and read data returns through registered per-port response channels.

Parameters:
MAX_WAIT, 4, number of consecutive denied dbg request cycles after which dbg wins over core (0 = dbg strict priority)
STALL_W, 16, width of the core stall statistics counter

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  synchronous reset, active-high
i_c_req  input  1  core request valid
i_c_we  input  1  core request is a write
i_c_addr  input  32  core word address (memory uses [4:0])
i_c_wdata  input  32  core write data
o_c_gnt  output  1  core request accepted this cycle (combinational)
o_c_rvalid  output  1  core read data valid
o_c_rdata  output  32  core read data
i_d_req  input  1  dbg request valid
i_d_we  input  1  dbg request is a write
i_d_addr  input  32  dbg word address
i_d_wdata  input  32  dbg write data
o_d_gnt  output  1  dbg request accepted this cycle (combinational)
o_d_rvalid  output  1  dbg read data valid
o_d_rdata  output  32  dbg read data
o_mem_we  output  1  memory write enable (registered)
o_mem_addr  output  32  memory address (registered)
o_mem_wdata  output  32  memory write data (registered)
i_mem_rdata  input  32  memory combinational read data
o_stall_cnt  output  STALL_W  saturating count of cycles with i_c_req=1 and o_c_gnt=0

Behaviour:
- Reset (i_rst=1 at posedge): all registered outputs, the wait counter and the internal pending-read flags go to 0. o_*_gnt is 0 while i_rst=1. A reset mid-operation drops any in-flight read: no rvalid follows.
- Grant (cycle N, combinational): at most one grant per cycle. The requesters are never both granted.
  - Only one port requesting: that port is granted.
  - Both requesting: dbg is granted if wait_cnt >= MAX_WAIT; otherwise core is granted.
  - No request: no grant.
- wait_cnt (width clog2(MAX_WAIT+1)), updated each cycle:
  - cleared when i_d_req=0 or o_d_gnt=1;
  - otherwise incremented, saturating at MAX_WAIT.
- Command stage (N+1): on a grant, the granted port's addr and wdata are registered into o_mem_addr/o_mem_wdata, and o_mem_we = granted we.
  - With no grant, o_mem_we = 0 next cycle and addr/wdata hold their previous values.
  - A write commits at the posedge ending N+1.
- Read response (N+2): a granted read sets a pending flag tagged with the port.
  - In N+1, i_mem_rdata is captured into that port's o_x_rdata.
  - o_x_rvalid = 1 for exactly cycle N+2; otherwise 0.
  - o_x_rdata holds its value when rvalid=0.
  - Writes produce no rvalid.
- Throughput: one request per cycle; back-to-back grants pipeline fully.
  - A read granted at N+1 after a write to the same address granted at N returns the new data: the write commits before the read's command cycle.
- o_stall_cnt increments each cycle i_c_req=1 && o_c_gnt=0 && i_rst=0, and saturates at all-ones.
- Requesters must hold req/we/addr/wdata stable until granted. The arbiter does not latch ungranted requests.

Test Plan:
- Reset: assert i_rst for 2 cycles with both req=1 -> gnt=0; o_mem_we=0, rvalid=0, o_stall_cnt=0; first grant in cycle after release goes to core.
- Core write/read: core write addr 3 data 0xDEADBEEF at N, read addr 3 at N+1 -> o_mem_we=1 in N+1; o_c_rvalid=1 at N+3 with o_c_rdata=0xDEADBEEF; o_d_rvalid stays 0.
- Starvation guard (MAX_WAIT=4): core and dbg both requesting continuously -> core granted cycles 0-3, dbg granted cycle 4, core cycles 5-8, dbg cycle 9; o_stall_cnt=2 after cycle 9.
- Dbg-only loader burst: dbg writes addrs 0,1,2 with values 1,2,3 on consecutive cycles, then reads addr 1 -> three o_mem_we pulses; o_d_rvalid with o_d_rdata=2 two cycles after the read grant.
- Reset mid-read: core read granted at N, i_rst=1 at N+1 -> o_c_rvalid never asserts; wait_cnt and o_stall_cnt return to 0.
- MAX_WAIT=0: both requesting -> dbg granted every cycle, core never granted; o_stall_cnt increments each cycle.
